// File: rtl/cflog_controller.sv
// ============================================================================
// cflog_controller
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences every hardware write into the CF-Log region of data memory.
//   Branch events (source/destination PC pairs) and, optionally, speculative
//   path IDs are buffered in a small FIFO. Each buffered entry is then
//   serialised into 16-bit word writes at the log write pointer. When the
//   next entry does not fit in the remaining log space, a TCB flush is
//   requested. The pointer rewinds to the region base when the TCB acks.
//
// Build option:
//   CFLOG_SPEC_EN  - when defined, the speculative-ID port is live and the
//                    FIFO carries a type bit (BR = 2 words, SP = 1 word).
//                    When undefined, spec_ready is tied low and spec_valid
//                    and spec_id are ignored. Every entry is a branch that
//                    costs 2 words.
//
// Ports:
//   clk          in   1   system clock, all logic on posedge
//   reset        in   1   synchronous, active-high reset
//   ev_valid     in   1   branch event offered
//   ev_src       in  16   branch source PC
//   ev_dst       in  16   branch destination PC
//   ev_ready     out  1   branch event accepted when ev_valid && ev_ready
//   spec_valid   in   1   speculative-path ID offered
//   spec_id      in   8   matched speculative-path ID
//   spec_ready   out  1   spec ID accepted when spec_valid && spec_ready
//   log_wr_en    out  1   one-cycle memory write strobe
//   log_wr_addr  out 16   byte address of the write
//   log_wr_data  out 16   word written
//   log_ptr      out 16   words written since last flush (0..LOG_SIZE)
//   flush_req    out  1   TCB flush request (level)
//   flush_ack    in   1   TCB done, sampled only while flushing
//   busy         out  1   FIFO non-empty or FSM not idle
// ============================================================================
module cflog_controller #(
    parameter logic [15:0] LOG_MIN    = 16'h01B0,
    parameter logic [15:0] LOG_SIZE   = 16'h0080,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  SPEC_TAG   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ev_valid,
    input  logic [15:0] ev_src,
    input  logic [15:0] ev_dst,
    output logic        ev_ready,
    input  logic        spec_valid,
    input  logic [7:0]  spec_id,
    output logic        spec_ready,
    output logic        log_wr_en,
    output logic [15:0] log_wr_addr,
    output logic [15:0] log_wr_data,
    output logic [15:0] log_ptr,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WR0   = 2'd1;
    localparam logic [1:0] ST_WR1   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [15:0]      r_log_ptr;
    logic             r_log_wr_en;
    logic [15:0]      r_log_wr_addr;
    logic [15:0]      r_log_wr_data;
    logic             r_flush_req;

    logic [31:0]      r_fifo_payload [FIFO_DEPTH];
`ifdef CFLOG_SPEC_EN
    logic             r_fifo_is_sp   [FIFO_DEPTH];
`endif
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // FIFO status and enqueue arbitration
    // ------------------------------------------------------------------
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_payload;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

`ifdef CFLOG_SPEC_EN
    logic w_push_sp;
    logic w_push_br;

    // A pending spec ID masks ev_ready, so at most one source pushes per
    // cycle. The spec requester wins a tie.
    assign spec_ready     = !w_full;
    assign ev_ready       = !w_full && !spec_valid;
    assign w_push_sp      = spec_valid && spec_ready;
    assign w_push_br      = ev_valid && ev_ready;
    assign w_push         = w_push_sp || w_push_br;
    assign w_push_payload = w_push_sp ? {24'd0, spec_id} : {ev_src, ev_dst};
`else
    logic w_unused;

    assign spec_ready     = 1'b0;
    assign ev_ready       = !w_full;
    assign w_push         = ev_valid && ev_ready;
    assign w_push_payload = {ev_src, ev_dst};
    assign w_unused       = &{1'b0, spec_valid, spec_id};
`endif

    // ------------------------------------------------------------------
    // Head-of-FIFO decode
    // ------------------------------------------------------------------
    logic [31:0] w_head_payload;
    logic        w_head_is_sp;
    logic [16:0] w_need;
    logic        w_fits;
    logic [15:0] w_wr_addr;
    logic [15:0] w_head_word0;

    assign w_head_payload = r_fifo_payload[r_rd_ptr];
`ifdef CFLOG_SPEC_EN
    assign w_head_is_sp   = r_fifo_is_sp[r_rd_ptr];
`else
    assign w_head_is_sp   = 1'b0;
`endif

    // The fit test is done at 17 bits so that log_ptr == LOG_SIZE cannot
    // wrap into a false "fits".
    assign w_need       = w_head_is_sp ? 17'd1 : 17'd2;
    assign w_fits       = ({1'b0, r_log_ptr} + w_need) <= {1'b0, LOG_SIZE};
    assign w_wr_addr    = LOG_MIN + {r_log_ptr[14:0], 1'b0};
    assign w_head_word0 = w_head_is_sp ? {SPEC_TAG, w_head_payload[7:0]}
                                       : w_head_payload[31:16];

    // The entry leaves the FIFO in the cycle its last word is on the bus.
    assign w_pop = ((r_state == ST_WR0) && w_head_is_sp) || (r_state == ST_WR1);

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset. Its contents are only read
    // behind r_count, which is reset, so clearing the data would add
    // logic without changing behaviour.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_payload[r_wr_ptr] <= w_push_payload;
`ifdef CFLOG_SPEC_EN
            r_fifo_is_sp[r_wr_ptr]   <= w_push_sp;
`endif
        end
    end

    // FIFO pointers and occupancy. Push and pop in the same cycle leave
    // the count unchanged. Pointers wrap naturally because the depth is a
    // power of two.
    // NOTE: every sequential assignment is non-blocking so that all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write sequencer
    // ------------------------------------------------------------------
    // All bus outputs are registered. The strobe, address and data for a
    // word are loaded on the edge that enters WR0/WR1, so the write is
    // visible during that state. log_ptr advances on the same edge.
    // Address and data hold their last values between writes, and only
    // log_wr_en qualifies them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_log_ptr     <= '0;
            r_log_wr_en   <= 1'b0;
            r_log_wr_addr <= '0;
            r_log_wr_data <= '0;
            r_flush_req   <= 1'b0;
        end else begin
            r_log_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_fits) begin
                            r_state       <= ST_WR0;
                            r_log_wr_en   <= 1'b1;
                            r_log_wr_addr <= w_wr_addr;
                            r_log_wr_data <= w_head_word0;
                            r_log_ptr     <= r_log_ptr + 16'd1;
                        end else begin
                            r_state     <= ST_FLUSH;
                            r_flush_req <= 1'b1;
                        end
                    end
                end

                ST_WR0: begin
                    if (w_head_is_sp) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // log_ptr already counts the source word, so the
                        // current pointer addresses the destination word.
                        r_state       <= ST_WR1;
                        r_log_wr_en   <= 1'b1;
                        r_log_wr_addr <= w_wr_addr;
                        r_log_wr_data <= w_head_payload[15:0];
                        r_log_ptr     <= r_log_ptr + 16'd1;
                    end
                end

                ST_WR1: begin
                    r_state <= ST_IDLE;
                end

                ST_FLUSH: begin
                    // The entry that did not fit stays at the FIFO head.
                    // It is written at LOG_MIN once the pointer rewinds.
                    if (flush_ack) begin
                        r_state     <= ST_IDLE;
                        r_log_ptr   <= '0;
                        r_flush_req <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign log_wr_en   = r_log_wr_en;
    assign log_wr_addr = r_log_wr_addr;
    assign log_wr_data = r_log_wr_data;
    assign log_ptr     = r_log_ptr;
    assign flush_req   = r_flush_req;
    assign busy        = !w_empty || (r_state != ST_IDLE);

endmodule

// File: doc/cflog_controller.md
Name: cflog_controller

Overview:
- Sequences all hardware writes into the CF-Log region of data memory.
- Accepts branch events (source/destination pairs) from the branch detector and speculative-path IDs from the SpecCFA path matcher, and buffers them in a small FIFO.
- Serialises each buffered entry into 16-bit word writes at the log write pointer.
- Requests a TCB flush when the log cannot hold the next entry, and rewinds the pointer when the TCB acknowledges.

Parameters:
- LOG_MIN, 16'h01B0, byte base address of CF-Log region.
- LOG_SIZE, 16'h0080, capacity of CF-Log in 2-byte words.
- FIFO_DEPTH, 4, number of buffered entries; power of two, at least 2.
- SPEC_TAG, 8'hFF, upper byte of a speculative-ID log word.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ev_valid  in  1  branch event offered.
- ev_src  in  16  branch source PC.
- ev_dst  in  16  branch destination PC.
- ev_ready  out  1  branch event accepted when ev_valid && ev_ready.
- spec_valid  in  1  speculative-path ID offered.
- spec_id  in  8  matched speculative-path ID.
- spec_ready  out  1  spec ID accepted when spec_valid && spec_ready.
- log_wr_en  out  1  one-cycle memory write strobe.
- log_wr_addr  out  16  byte address of the write.
- log_wr_data  out  16  word written.
- log_ptr  out  16  words written since last flush; range 0..LOG_SIZE.
- flush_req  out  1  TCB flush request; level signal.
- flush_ack  in  1  TCB done; sampled only in FLUSH.
- busy  out  1  high when FIFO non-empty or state != IDLE.

Behaviour:
- Reset (sync, high) gives: state IDLE, FIFO empty, log_ptr 0, log_wr_en 0, log_wr_addr 0, log_wr_data 0, flush_req 0.
- Reset mid-write or mid-flush abandons the operation; no further writes are issued.
- FIFO entry: 1-bit type (BR/SP) plus 32-bit payload.
- Readiness:
  - ev_ready = FIFO count < FIFO_DEPTH && !spec_valid.
  - spec_ready = FIFO count < FIFO_DEPTH.
  - When both requesters are valid in the same cycle, spec wins; the branch event waits.
- Enqueue at most one entry per cycle. Simultaneous enqueue and dequeue keeps the count unchanged.
- Words needed per entry: BR = 2, SP = 1.
- State machine, with all outputs registered:
  - IDLE:
    - If the FIFO is non-empty and log_ptr + need <= LOG_SIZE, go to WR0.
    - If the FIFO is non-empty and log_ptr + need > LOG_SIZE, go to FLUSH.
    - Otherwise stay in IDLE.
  - WR0:
    - Drive log_wr_en = 1, log_wr_addr = LOG_MIN + 2*log_ptr, and data = ev_src (BR) or {SPEC_TAG, spec_id} (SP); log_ptr++.
    - BR goes to WR1.
    - SP pops the FIFO and returns to IDLE.
  - WR1:
    - Drive a write of ev_dst at the next address; log_ptr++.
    - Pop the FIFO and return to IDLE.
  - FLUSH:
    - flush_req = 1; hold in FLUSH until flush_ack = 1.
    - On ack: log_ptr <= 0, flush_req <= 0, go to IDLE. The pending entry is then written at LOG_MIN.
- Latency: a handshake in cycle N gives a FIFO entry in N+1, the FSM leaves IDLE in N+1, and the first log_wr_en is high in N+2.
- Throughput: BR costs 3 cycles per entry, SP costs 2.
- log_wr_en is low in every cycle except WR0 and WR1.
- Addresses never exceed LOG_MIN + 2*(LOG_SIZE-1).
- log_ptr == LOG_SIZE is legal; a flush is requested only when the next entry arrives.
- flush_ack outside FLUSH is ignored.
- Enqueue continues during FLUSH until the FIFO is full.
- Address arithmetic is 16-bit unsigned; no wrap is possible within the parameter limits.

Optional Feature:
- Macro CFLOG_SPEC_EN.
  - Defined: spec port behaves as above.
  - Undefined: spec_ready tied to 0, spec_valid and spec_id ignored, ev_ready = FIFO count < FIFO_DEPTH, FIFO type bit removed, every entry costs 2 words.

Test Plan:
- Reset, then one branch (0xE010 -> 0xE200) in cycle 1:
  - Cycle 3: write 0xE010 @0x01B0.
  - Cycle 4: write 0xE200 @0x01B2.
  - log_ptr = 2, busy low from cycle 5.
- Same cycle ev_valid and spec_valid (id 0x05):
  - ev_ready = 0 that cycle.
  - First write is 0xFF05, then the branch pair at the next two addresses.
- 64 back-to-back branches:
  - 128 writes, last at 0x02AE, log_ptr = 0x80, flush_req stays 0.
  - 65th branch: flush_req = 1.
  - flush_ack after 5 cycles: log_ptr = 0 and that branch is written at 0x01B0.
- log_ptr = 0x7F:
  - Spec ID is written at 0x02AE, log_ptr = 0x80.
  - A following branch triggers FLUSH.
- FIFO backpressure: hold flush_ack low in FLUSH while offering 5 events:
  - ev_ready falls after the FIFO holds 4 entries.
  - No event is lost or duplicated after ack.
- Reset asserted during WR1: next cycle log_wr_en = 0, log_ptr = 0, FIFO empty, flush_req = 0.
